change_dispenser: RTL

Downstream stage of the change calculator. Takes the registered change amount, 0–31 units, and pays it out one coin at a time to the coin-eject mechanism. It uses greedy denomination selection over three coin tubes, each with its own inventory counter. A ready/valid handshake lets the mechanism stall each ejection. The block reports completion and flags when inventory cannot cover the full amount.

---
 rtl/change_dispenser.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Pays out a change amount (0..31 units) one coin at a time using greedy
// denomination selection over three coin tubes (A, B, and C = 1 unit), each
// with its own inventory counter. The coin-eject mechanism may stall each
// ejection. Completion is pulsed on done. A payout that inventory cannot cover
// ends with short set.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, overrides every other input
//   start        load change_in and begin payout (IDLE only)
//   change_in    amount to pay out, sampled when start is accepted
//   refill       set all inventories to all-ones (IDLE only; start has priority)
//   eject_ready  mechanism accepts the presented coin this cycle
//   eject_valid  a coin request is presented
//   eject_sel    coin code: 01=A, 10=B, 11=C, 00 when no coin is selected
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a payout ends
//   short        payout ended with remaining > 0; cleared by the next start
//   remaining    units still owed
//   inv_a/b/c    tube inventories
//   dbg_state    current FSM state (0=IDLE, 1=SELECT, 2=EJECT, 3=FINISH)
//
// Handshake: eject_valid is high for the whole of EJECT. eject_sel is held
// stable while eject_valid=1 and eject_ready=0. A coin transfers on exactly
// the rising edge where eject_valid=1 and eject_ready=1. valid never drops
// before that edge.

module change_dispenser #(
    parameter int COIN_A   = 10,
    parameter int COIN_B   = 5,
    parameter int INV_W    = 4,
    parameter int INV_INIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       change_in,
    input  logic             refill,
    input  logic             eject_ready,
    output logic             eject_valid,
    output logic [1:0]       eject_sel,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [4:0]       remaining,
    output logic [INV_W-1:0] inv_a,
    output logic [INV_W-1:0] inv_b,
    output logic [INV_W-1:0] inv_c,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [4:0]       VAL_A    = 5'(COIN_A);
    localparam logic [4:0]       VAL_B    = 5'(COIN_B);
    localparam logic [4:0]       VAL_C    = 5'd1;
    localparam logic [INV_W-1:0] INV_FULL = '1;
    localparam logic [INV_W-1:0] INV_RST  = INV_W'(INV_INIT);
    localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    state_t     state;
    logic [4:0] sel_value;

    // Status outputs are pure decodes of the state register, so they carry no
    // input-to-output path.
    assign eject_valid = (state == EJECT);
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);
    assign dbg_state   = state;

    // Value of the coin currently being ejected.
    always_comb begin
        sel_value = 5'd0;
        case (eject_sel)
            SEL_A:   sel_value = VAL_A;
            SEL_B:   sel_value = VAL_B;
            SEL_C:   sel_value = VAL_C;
            default: sel_value = 5'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 5'd0;
            eject_sel <= SEL_NONE;
            short     <= 1'b0;
            inv_a     <= INV_RST;
            inv_b     <= INV_RST;
            inv_c     <= INV_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_in;
                        short     <= 1'b0;
                        state     <= SELECT;
                    end else if (refill) begin
                        inv_a <= INV_FULL;
                        inv_b <= INV_FULL;
                        inv_c <= INV_FULL;
                    end
                end

                // Greedy choice: the largest coin that fits and is in stock.
                // Because value <= remaining is required, remaining never underflows.
                SELECT: begin
                    if (remaining == 5'd0) begin
                        state <= FINISH;
                    end else if (remaining >= VAL_A && inv_a != '0) begin
                        eject_sel <= SEL_A;
                        state     <= EJECT;
                    end else if (remaining >= VAL_B && inv_b != '0) begin
                        eject_sel <= SEL_B;
                        state     <= EJECT;
                    end else if (inv_c != '0) begin
                        eject_sel <= SEL_C;
                        state     <= EJECT;
                    end else begin
                        short <= 1'b1;
                        state <= FINISH;
                    end
                end

                EJECT: begin
                    if (eject_ready) begin
                        remaining <= remaining - sel_value;
                        case (eject_sel)
                            SEL_A:   inv_a <= inv_a - INV_ONE;
                            SEL_B:   inv_b <= inv_b - INV_ONE;
                            SEL_C:   inv_c <= inv_c - INV_ONE;
                            default: ;
                        endcase
                        eject_sel <= SEL_NONE;
                        state     <= SELECT;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
